// File: rtl/serial_subn_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings and the
// counter-width helper.
package serial_subn_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  // Bit counter only needs to reach n-1.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subn_if.sv
// Operand/result handshake bundle for serial_subn (start/busy/done plus data).
interface serial_subn_if #(parameter int N = 8);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic         bout;

  modport master (output start, a, b, bin, input  busy, done, q, bout);
  modport slave  (input  start, a, b, bin, output busy, done, q, bout);

endinterface

// File: rtl/fullsub1.sv
// One-bit full-subtractor slice: d = x - y - bi, bo = borrow out.
module fullsub1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic xy_diff;

  assign xy_diff = x ^ y;
  assign d       = xy_diff ^ bi;
  assign bo      = (~x & y) | (~xy_diff & bi);

endmodule

// File: rtl/serial_subn.sv
// Bit-serial N-bit subtractor: one fullsub1 slice reused LSB-first over N
// cycles, with a start/busy/done handshake and results held until the next completion.
module serial_subn
  import serial_subn_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_subn_if.slave bus
);

  localparam int CW = cnt_w(N);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  diff_sh;
  logic          br;
  logic          d;
  logic          bo;
  logic          accept;
  logic          last;

  assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (state == S_SHIFT) && (cnt == CW'(N - 1));

  fullsub1 u_slice (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.q    <= '0;
      bus.bout <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state    <= S_SHIFT;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (last) begin
            // Top bit of diff_sh is still clear here; merge the final bit in.
            state    <= S_DONE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.q    <= diff_sh | (N'(d) << (N - 1));
            bus.bout <= bo;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Operand/result shift registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      br      <= bus.bin;
      diff_sh <= '0;
    end else if (state == S_SHIFT) begin
      a_sh         <= a_sh >> 1;
      b_sh         <= b_sh >> 1;
      br           <= bo;
      diff_sh[cnt] <= d;
    end
  end

endmodule

// File: tb/tb_serial_subn.sv
// Self-checking bench for serial_subn: vector table, corner sweep, random ops
// and hand-written handshake/reset sequences, scored through an expected-result queue.
module tb_serial_subn;

  localparam int N = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  serial_subn_if #(.N(N)) bus ();

  serial_subn #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [8:0] sb[$];
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'd0, bin};
  endfunction

  // Output monitor: every done pulse pops one expected {bout,q}.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got q=0x%0h bout=%0b with no operation pending", bus.q, bus.bout);
      end else begin
        check("result", {23'd0, bus.bout, bus.q}, {23'd0, sb.pop_front()});
      end
    end
  end

  task automatic wait_done(output int busy_cnt, output bit got);
    busy_cnt = 0;
    got      = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic [8:0] exp);
    int  bc;
    bit  got;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(bc, got);
    check("busy_len", bc, N);
    check("done_seen", {31'd0, got}, 1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];
  logic [7:0] corners[6];

  initial begin
    int  bc;
    bit  got;
    int  saved;
    logic [7:0] ra, rb;
    logic       rbin;

    vecs[0] = '{a: 8'h5A, b: 8'h23, bin: 1'b0, exp: 9'h037};
    vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, exp: 9'h1FF};
    vecs[2] = '{a: 8'h80, b: 8'h7F, bin: 1'b1, exp: 9'h000};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, exp: 9'h1FF};
    vecs[4] = '{a: 8'h00, b: 8'h00, bin: 1'b1, exp: 9'h1FF};
    vecs[5] = '{a: 8'hFF, b: 8'h00, bin: 1'b0, exp: 9'h0FF};
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFE; corners[5] = 8'hFF;

    // Reset with start held high: nothing may begin.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h11;
    bus.bin   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_q", {24'd0, bus.q}, 0);
    check("rst_bout", {31'd0, bus.bout}, 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, bus.busy}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);

    // Busy protection, then start held through the done cycle.
    bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
    sb.push_back(9'h00F);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'h03; bus.b = 8'h05; bus.bin = 1'b0; bus.start = 1'b1;
    sb.push_back(9'h1FE);
    wait_done(bc, got);
    check("b2b_first_done", {31'd0, got}, 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(bc, got);
    check("b2b_busy_len", bc, N);
    check("b2b_second_done", {31'd0, got}, 1);
    @(posedge clk); #1;

    // Reset in the middle of an operation discards it.
    bus.a = 8'h44; bus.b = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
    sb.push_back(9'h033);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    saved = done_cnt;
    @(negedge clk);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_q", {24'd0, bus.q}, 0);
    check("midrst_bout", {31'd0, bus.bout}, 0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, saved);
    do_op(8'h09, 8'h04, 1'b0, 9'h005);

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int k = 0; k < 2; k++)
          do_op(corners[i], corners[j], k[0], model(corners[i], corners[j], k[0]));

    for (int n = 0; n < 3000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      do_op(ra, rb, rbin, model(ra, rb, rbin));
    end

    repeat (3) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "timeout");
  end

endmodule
